alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
- Upstream issue stage for the 4-bit ALU: accepts 8-bit instruction bytes over a valid/ready handshake and decodes them.
- Reads operands from a 4-entry x 4-bit register file and drives the ALU's opcode, operands and enable.
- Waits the ALU latency, then writes the ALU result back to the destination register.
- Also executes a two-byte load-immediate (LDI) without using the ALU.

Parameters:
- ALU_LAT, 1, cycles from ALU operands/enable valid to alu_result valid (legal 1..7).
- NREG, 4, register file entries; fixed by the 2-bit register fields, not user-overridable.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  stage enable; low freezes all state.
- instr_valid  in  1  instruction byte offered.
- instr_data  in  8  instruction byte: [7:5] opcode, [4:3] rd, [2:1] rs, [0] reserved (ignored).
- instr_ready  out  1  stage can accept a byte this cycle.
- alu_opcode  out  3  opcode to ALU.
- alu_in_1  out  4  R[rd] operand.
- alu_in_2  out  4  R[rs] operand.
- alu_en  out  1  high while the ALU operation is in flight.
- alu_result  in  4  ALU output, sampled ALU_LAT cycles after alu_en rises.
- wb_valid  out  1  one-cycle pulse on every register write.
- wb_addr  out  2  register written.
- wb_data  out  4  value written.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State = IDLE; R0..R3 = 0; latency counter = 0.
  - instr_ready = 0 while rst_n is low, 1 in the first cycle after release (IDLE).
  - alu_opcode/alu_in_1/alu_in_2 = 0; alu_en, wb_valid, wb_addr, wb_data = 0.
- Handshake: a byte transfers on a rising edge with instr_valid & instr_ready & ena. instr_ready is high only in IDLE and IMM, and only when ena = 1.
- State machine:
  - IDLE: on transfer, latch opcode/rd/rs.
    - If opcode != 3'b111, go to EXEC.
    - If opcode == 3'b111 (LDI), go to IMM.
  - EXEC:
    - Registered outputs: alu_opcode = latched opcode; alu_in_1 = R[rd] and alu_in_2 = R[rs], read at entry. alu_en = 1.
    - Counter counts ALU_LAT cycles; on the last, go to WB.
    - Operand outputs hold stable for the whole of EXEC.
  - WB:
    - Sample alu_result; write R[rd] = alu_result.
    - Pulse wb_valid for 1 cycle with wb_addr = rd, wb_data = alu_result.
    - alu_en = 0; go to IDLE.
  - IMM (second byte of LDI): instr_ready = 1. On transfer:
    - R[rd] = instr_data[3:0]; instr_data[7:4] is ignored.
    - Pulse wb_valid the following cycle; go to IDLE.
- Latency:
  - ALU instruction: transfer edge -> wb_valid high = ALU_LAT + 1 cycles. Back-to-back issue rate is one per ALU_LAT + 2 cycles.
  - LDI: second-byte edge -> wb_valid next cycle.
- Hazards: none possible. Writeback completes before IDLE accepts the next byte, so a dependent instruction always reads the updated register.
- rd == rs is legal; both operands equal R[rd].
- Widths: all data is 4-bit; the ALU owns wrap/overflow. This block never modifies alu_result.
- ena low: all state, counter, registers and outputs hold; instr_ready = 0; wb_valid = 0. A wb pulse due in that cycle is deferred until ena returns.
- instr_valid with ena low: no transfer; the byte must be held by the source.
- Reset asserted mid-operation: EXEC/IMM is abandoned, the partially issued instruction is lost, registers clear, and no wb_valid pulse is emitted.
- instr_data bit 0: ignored.

Decomposition:
- Shared package holds:
  - Opcode localparams: OP_LDI = 3'b111; ALU opcodes 000..110 are shared with the ALU.
  - Instruction field position constants.
  - State encoding: IDLE, EXEC, WB, IMM.
- One natural sub-module: alu_regfile (4x4, 2 async read ports, 1 sync write port, async clear).

Test Plan:
- Reset then idle: assert rst_n = 0 mid-run -> R0..R3 = 0, instr_ready = 0 during reset and 1 the cycle after release, all outputs 0.
- LDI: send 8'b111_01_000 then 8'h0A -> wb_valid pulse with wb_addr = 1, wb_data = 4'hA, R1 = 4'hA.
- ALU op, stub ALU = in_1 + in_2 mod 16, ALU_LAT = 1: with R1 = 9, R2 = 8, send 8'b000_01_100 -> alu_in_1 = 9, alu_in_2 = 8, alu_en high 1 cycle; wb_valid 2 cycles after the transfer with wb_data = 4'h1, R1 = 1.
- Back-to-back dependent ops, ALU_LAT = 3, instr_valid held high: second op reads the first's result; instr_ready low for exactly 4 cycles between acceptances.
- ena dropped for 5 cycles during EXEC: alu_en, operands and counter frozen; writeback completes exactly 5 cycles late with the correct value.
- rst_n pulsed during EXEC: no wb_valid pulse, registers 0, next LDI works normally.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl_pkg
// Shared definitions for the ALU issue stage: instruction field positions,
// opcode constants, register-file geometry and the issue FSM state encoding.
// -----------------------------------------------------------------------------
package alu_issue_ctrl_pkg;

   localparam int INSTR_W = 8;
   localparam int REG_W   = 4;
   localparam int RADDR_W = 2;
   localparam int NREG    = 4;
   localparam int OP_W    = 3;

   // Instruction byte layout: [7:5] opcode, [4:3] rd, [2:1] rs, [0] reserved
   localparam int OPC_MSB = 7;
   localparam int OPC_LSB = 5;
   localparam int RD_MSB  = 4;
   localparam int RD_LSB  = 3;
   localparam int RS_MSB  = 2;
   localparam int RS_LSB  = 1;

   // Second LDI byte: immediate sits in the low nibble, upper nibble unused
   localparam int IMM_MSB = 3;
   localparam int IMM_LSB = 0;

   // Opcodes 3'b000..3'b110 are passed straight to the ALU
   localparam logic [OP_W-1:0] OP_LDI = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2,
      ST_IMM  = 2'd3
   } state_e;

   function automatic logic [OP_W-1:0] f_opc(input logic [INSTR_W-1:0] instr);
      return instr[OPC_MSB:OPC_LSB];
   endfunction

   function automatic logic [RADDR_W-1:0] f_rd(input logic [INSTR_W-1:0] instr);
      return instr[RD_MSB:RD_LSB];
   endfunction

   function automatic logic [RADDR_W-1:0] f_rs(input logic [INSTR_W-1:0] instr);
      return instr[RS_MSB:RS_LSB];
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// -----------------------------------------------------------------------------
// alu_regfile
// 4 x 4-bit register file: two asynchronous read ports, one synchronous write
// port, asynchronous clear on rst_n.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low clear of all entries
//   we_i       in   write enable (sampled on rising clk)
//   waddr_i    in   write address
//   wdata_i    in   write data
//   raddr_a_i  in   read port A address
//   raddr_b_i  in   read port B address
//   rdata_a_o  out  read port A data
//   rdata_b_o  out  read port B data
// -----------------------------------------------------------------------------
module alu_regfile
   import alu_issue_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               we_i,
   input  logic [RADDR_W-1:0] waddr_i,
   input  logic [REG_W-1:0]   wdata_i,
   input  logic [RADDR_W-1:0] raddr_a_i,
   input  logic [RADDR_W-1:0] raddr_b_i,
   output logic [REG_W-1:0]   rdata_a_o,
   output logic [REG_W-1:0]   rdata_b_o
);

   logic [REG_W-1:0] regs_q [NREG];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = regs_q[raddr_a_i];
   assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Issue stage for the 4-bit ALU. Accepts instruction bytes over valid/ready,
// reads operands from the register file, drives the ALU for ALU_LAT cycles,
// then writes the ALU result back. LDI (opcode 3'b111) takes a second byte
// whose low nibble is written directly to R[rd].
//
// Parameters:
//   ALU_LAT      cycles from operands/enable valid to alu_result valid (1..7)
//
// Ports:
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   ena          in   stage enable; low freezes all state
//   instr_valid  in   instruction byte offered
//   instr_data   in   instruction byte {opcode, rd, rs, reserved}
//   instr_ready  out  byte accepted this cycle when instr_valid is high
//   alu_opcode   out  opcode to ALU
//   alu_in_1     out  R[rd] operand
//   alu_in_2     out  R[rs] operand
//   alu_en       out  high while the ALU operation is in flight
//   alu_result   in   ALU output, valid ALU_LAT cycles after alu_en rises
//   wb_valid     out  one-cycle pulse on every register write
//   wb_addr      out  register written
//   wb_data      out  value written
// -----------------------------------------------------------------------------
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
#(
   parameter int ALU_LAT = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic               instr_valid,
   input  logic [INSTR_W-1:0] instr_data,
   output logic               instr_ready,
   output logic [OP_W-1:0]    alu_opcode,
   output logic [REG_W-1:0]   alu_in_1,
   output logic [REG_W-1:0]   alu_in_2,
   output logic               alu_en,
   input  logic [REG_W-1:0]   alu_result,
   output logic               wb_valid,
   output logic [RADDR_W-1:0] wb_addr,
   output logic [REG_W-1:0]   wb_data
);

   localparam logic [2:0] CNT_LAST = 3'(ALU_LAT - 1);

   state_e             state_q, state_d;
   logic [2:0]         cnt_q, cnt_d;
   logic [RADDR_W-1:0] rd_q, rd_d;
   logic [OP_W-1:0]    alu_opcode_q, alu_opcode_d;
   logic [REG_W-1:0]   alu_in_1_q, alu_in_1_d;
   logic [REG_W-1:0]   alu_in_2_q, alu_in_2_d;
   logic               wb_valid_q, wb_valid_d;
   logic [RADDR_W-1:0] wb_addr_q, wb_addr_d;
   logic [REG_W-1:0]   wb_data_q, wb_data_d;

   logic               xfer;
   logic               rf_we;
   logic [REG_W-1:0]   rf_wdata;
   logic [REG_W-1:0]   rf_rdata_a;
   logic [REG_W-1:0]   rf_rdata_b;

   // rst_n gates ready so the source never sees a transfer opportunity during reset
   assign instr_ready = rst_n & ena & ((state_q == ST_IDLE) | (state_q == ST_IMM));
   assign xfer        = instr_valid & instr_ready;

   // Operands are read straight from the incoming byte's fields so they can be
   // registered on the same edge that accepts the instruction.
   alu_regfile u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_i      (rf_we),
      .waddr_i   (rd_q),
      .wdata_i   (rf_wdata),
      .raddr_a_i (f_rd(instr_data)),
      .raddr_b_i (f_rs(instr_data)),
      .rdata_a_o (rf_rdata_a),
      .rdata_b_o (rf_rdata_b)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rd_d         = rd_q;
      alu_opcode_d = alu_opcode_q;
      alu_in_1_d   = alu_in_1_q;
      alu_in_2_d   = alu_in_2_q;
      wb_valid_d   = 1'b0;
      wb_addr_d    = wb_addr_q;
      wb_data_d    = wb_data_q;
      rf_we        = 1'b0;
      rf_wdata     = alu_result;

      case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               rd_d = f_rd(instr_data);
               if (f_opc(instr_data) == OP_LDI) begin
                  state_d = ST_IMM;
               end else begin
                  state_d      = ST_EXEC;
                  cnt_d        = '0;
                  alu_opcode_d = f_opc(instr_data);
                  alu_in_1_d   = rf_rdata_a;
                  alu_in_2_d   = rf_rdata_b;
               end
            end
         end
         ST_EXEC: begin
            if (cnt_q == CNT_LAST) begin
               state_d = ST_WB;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         ST_WB: begin
            // Register file is not clock-enabled, so the write must honour ena
            rf_we      = ena;
            rf_wdata   = alu_result;
            wb_valid_d = 1'b1;
            wb_addr_d  = rd_q;
            wb_data_d  = alu_result;
            state_d    = ST_IDLE;
         end
         ST_IMM: begin
            if (xfer) begin
               rf_we      = 1'b1;
               rf_wdata   = instr_data[IMM_MSB:IMM_LSB];
               wb_valid_d = 1'b1;
               wb_addr_d  = rd_q;
               wb_data_d  = instr_data[IMM_MSB:IMM_LSB];
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         rd_q         <= '0;
         alu_opcode_q <= '0;
         alu_in_1_q   <= '0;
         alu_in_2_q   <= '0;
         wb_valid_q   <= 1'b0;
         wb_addr_q    <= '0;
         wb_data_q    <= '0;
      end else if (ena) begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rd_q         <= rd_d;
         alu_opcode_q <= alu_opcode_d;
         alu_in_1_q   <= alu_in_1_d;
         alu_in_2_q   <= alu_in_2_d;
         wb_valid_q   <= wb_valid_d;
         wb_addr_q    <= wb_addr_d;
         wb_data_q    <= wb_data_d;
      end
   end

   assign alu_opcode = alu_opcode_q;
   assign alu_in_1   = alu_in_1_q;
   assign alu_in_2   = alu_in_2_q;
   assign alu_en     = (state_q == ST_EXEC);
   // A pending pulse is masked while ena is low and shows once ena returns,
   // because wb_valid_q only clears on an enabled edge.
   assign wb_valid   = wb_valid_q & ena;
   assign wb_addr    = wb_addr_q;
   assign wb_data    = wb_data_q;

endmodule
